// File: rtl/vendor_pkg.sv
// Shared definitions for the vendor front end.
//   - coin code constants and their face values
//   - coin_value(): code -> value lookup
//   - onehot_to_code(): slot sensor pattern -> coin code
//   - coin FSM state enum
//   - default width of the credit accumulator
package vendor_pkg;

    localparam int CREDIT_W_DEF = 9;

    localparam logic [1:0] COIN_C1  = 2'b00;
    localparam logic [1:0] COIN_C2  = 2'b01;
    localparam logic [1:0] COIN_C5  = 2'b10;
    localparam logic [1:0] COIN_C10 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL,
        ST_EMIT,
        ST_HOLD,
        ST_REJ
    } coin_state_e;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] value;
        case (code)
            COIN_C1:  value = 4'd1;
            COIN_C2:  value = 4'd2;
            COIN_C5:  value = 4'd5;
            default:  value = 4'd10;
        endcase
        return value;
    endfunction

    // Only called with a one-hot pattern; the highest set bit wins otherwise.
    function automatic logic [1:0] onehot_to_code(input logic [3:0] pattern);
        logic [1:0] code;
        code = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (pattern[i]) begin
                code = i[1:0];
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Bundle between the coin acceptor and its environment.
//   master: drives raw sensors/button and clear_credit, observes the Vendor-side outputs
//   slave : the coin acceptor itself
// Signals: coin_sense[3:0], finish_btn, clear_credit (to acceptor);
//          coin[1:0], drop_coin, finish_coin, reject, jam, credit[CREDIT_W-1:0] (from acceptor)
interface coin_acceptor_if
    import vendor_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
);
    logic [3:0]          coin_sense;
    logic                finish_btn;
    logic                clear_credit;
    logic [1:0]          coin;
    logic                drop_coin;
    logic                finish_coin;
    logic                reject;
    logic                jam;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_sense, finish_btn, clear_credit,
        input  coin, drop_coin, finish_coin, reject, jam, credit
    );

    modport slave (
        input  coin_sense, finish_btn, clear_credit,
        output coin, drop_coin, finish_coin, reject, jam, credit
    );
endinterface

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus stability qualifier for one raw button line.
// Ports: clk, reset (sync, active high), raw (asynchronous input),
//        pulse (one cycle when a press has been stable for DEBOUNCE_CYCLES samples).
// After a press is accepted the line must read low for DEBOUNCE_CYCLES samples
// before another press can be accepted.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_reg, sync2_reg;
    logic             armed_reg, armed_next;
    logic             pulse_reg, pulse_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            armed_reg <= 1'b1;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            armed_reg <= armed_next;
            pulse_reg <= pulse_next;
            cnt_reg   <= cnt_next;
        end
    end

    // While armed we wait for a stable high; once fired we wait for a stable low.
    // Both phases use the same counter, so the wanted level is simply armed_reg.
    always_comb begin
        armed_next = armed_reg;
        pulse_next = 1'b0;
        cnt_next   = cnt_reg;
        if (sync2_reg == armed_reg) begin
            if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_next   = '0;
                armed_next = ~armed_reg;
                pulse_next = armed_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    assign pulse = pulse_reg;
endmodule

// File: rtl/coin_acceptor.sv
// Front end of the Vendor FSM: turns raw coin-slot sensors and the finish
// button into one-cycle drop_coin / finish_coin pulses and keeps a credit total.
// Ports: clk, reset (sync, active high), bus (coin_acceptor_if.slave):
//   coin_sense/finish_btn raw inputs, clear_credit, coin, drop_coin,
//   finish_coin, reject, jam, credit.
// Optional: define COIN_AUTO_FINISH_EN to add an idle timer that issues
// finish_coin TIMEOUT_CYCLES after the last accepted coin.
module coin_acceptor
    import vendor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_HOLD_CYCLES = 256,
    parameter int CREDIT_W        = CREDIT_W_DEF
`ifdef COIN_AUTO_FINISH_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1000
`endif
) (
    input  logic           clk,
    input  logic           reset,
    coin_acceptor_if.slave bus
);
    localparam int CNT_MAX = (MAX_HOLD_CYCLES > DEBOUNCE_CYCLES) ? MAX_HOLD_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    coin_state_e         state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [3:0]          pat_reg, pat_next;
    logic [1:0]          coin_reg, coin_next;
    logic                reject_reg, reject_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [CREDIT_W:0]   credit_sum;
    logic [3:0]          sync1_reg, sync2_reg;
    logic                s_multi, s_one_hot;
    logic                btn_pulse;

    input_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_finish_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (bus.finish_btn),
        .pulse(btn_pulse)
    );

    // x & (x-1) clears the lowest set bit: non-zero means two or more lines.
    assign s_multi   = (sync2_reg & (sync2_reg - 4'd1)) != 4'd0;
    assign s_one_hot = (sync2_reg != 4'd0) && !s_multi;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            pat_reg    <= '0;
            coin_reg   <= '0;
            reject_reg <= 1'b0;
            credit_reg <= '0;
        end else begin
            sync1_reg  <= bus.coin_sense;
            sync2_reg  <= sync1_reg;
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pat_reg    <= pat_next;
            coin_reg   <= coin_next;
            reject_reg <= reject_next;
            credit_reg <= credit_next;
        end
    end

    // cnt_reg holds the stable-sample count in QUAL and the held-cycle count in HOLD.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pat_next    = pat_reg;
        coin_next   = coin_reg;
        reject_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (s_multi) begin
                    state_next  = ST_REJ;
                    reject_next = 1'b1;
                end else if (s_one_hot) begin
                    state_next = ST_QUAL;
                    pat_next   = sync2_reg;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_QUAL: begin
                if (sync2_reg != pat_reg) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_next = ST_EMIT;
                    cnt_next   = '0;
                    coin_next  = onehot_to_code(pat_reg);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_EMIT: begin
                state_next = ST_HOLD;
                cnt_next   = CNT_W'(1);
            end
            ST_HOLD: begin
                if (sync2_reg == 4'd0) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg != CNT_W'(MAX_HOLD_CYCLES)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_REJ: begin
                if (sync2_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Clear is applied first so a clear coinciding with EMIT leaves only the new coin.
    always_comb begin
        credit_next = bus.clear_credit ? '0 : credit_reg;
        credit_sum  = {1'b0, credit_next} + (CREDIT_W + 1)'(coin_value(coin_reg));
        if (state_reg == ST_EMIT) begin
            credit_next = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
        end
    end

    assign bus.coin      = coin_reg;
    assign bus.drop_coin = (state_reg == ST_EMIT);
    assign bus.reject    = reject_reg;
    assign bus.jam       = (state_reg == ST_HOLD) && (cnt_reg == CNT_W'(MAX_HOLD_CYCLES));
    assign bus.credit    = credit_reg;

`ifdef COIN_AUTO_FINISH_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    logic              idle_armed_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              auto_pulse_reg;

    // Loading 1 on EMIT counts the EMIT-exit edge itself, so the pulse lands
    // exactly TIMEOUT_CYCLES cycles after the EMIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_armed_reg <= 1'b0;
            idle_cnt_reg   <= '0;
            auto_pulse_reg <= 1'b0;
        end else begin
            auto_pulse_reg <= 1'b0;
            if (state_reg == ST_EMIT) begin
                idle_armed_reg <= 1'b1;
                idle_cnt_reg   <= IDLE_W'(1);
            end else if (bus.clear_credit || btn_pulse) begin
                idle_armed_reg <= 1'b0;
            end else if (idle_armed_reg) begin
                if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_armed_reg <= 1'b0;
                    auto_pulse_reg <= (credit_reg != '0);
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.finish_coin = btn_pulse | auto_pulse_reg;
`else
    assign bus.finish_coin = btn_pulse;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: every inserted coin pushes its expected
// code and credit; the monitor pops and compares on each drop_coin.
module tb_coin_acceptor;
    localparam int DEB  = 4;
    localparam int MAXH = 256;
    localparam int CW   = 9;
    localparam int CMAX = (1 << CW) - 1;
`ifdef COIN_AUTO_FINISH_EN
    localparam int TMO  = 20;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coin_acceptor_if #(.CREDIT_W(CW)) bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_HOLD_CYCLES(MAXH),
        .CREDIT_W(CW)
`ifdef COIN_AUTO_FINISH_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt = 0, reject_cnt = 0, finish_cnt = 0, jam_cnt = 0;

    typedef struct {
        logic [1:0] code;
        int         credit;
    } exp_t;

    exp_t sb_q[$];
    int   exp_credit = 0;
    bit   credit_pending = 0;
    int   pending_credit = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int coin_val_model(input logic [1:0] c);
        case (c)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 10;
        endcase
    endfunction

    task automatic sb_push(input logic [1:0] code, input bit clr_at_emit);
        exp_t e;
        if (clr_at_emit) begin
            exp_credit = coin_val_model(code);
        end else begin
            exp_credit += coin_val_model(code);
            if (exp_credit > CMAX) exp_credit = CMAX;
        end
        e.code   = code;
        e.credit = exp_credit;
        sb_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            credit_pending = 0;
        end else begin
            if (credit_pending) begin
                check_eq("credit_after_drop", 32'(bus.credit), pending_credit);
                credit_pending = 0;
            end
            if (bus.drop_coin) begin
                exp_t e;
                drop_cnt++;
                check_eq("sb_nonempty_at_drop", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    $display("drop coin=%0d expected=%0d expected_credit=%0d", bus.coin, e.code, e.credit);
                    check_eq("coin_code", 32'(bus.coin), 32'(e.code));
                    pending_credit = e.credit;
                    credit_pending = 1;
                end
            end
            if (bus.reject)      reject_cnt++;
            if (bus.finish_coin) finish_cnt++;
            if (bus.jam)         jam_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic insert_coin(input logic [1:0] code, input int hold, input int gap);
        bus.coin_sense = 4'b0001 << code;
        sb_push(code, 1'b0);
        cycles(hold);
        bus.coin_sense = 4'b0000;
        cycles(gap);
    endtask

    task automatic pulse_clear();
        bus.clear_credit = 1'b1;
        cycles(1);
        bus.clear_credit = 1'b0;
        exp_credit = 0;
        cycles(1);
    endtask

    task automatic press(input int high, input int low);
        bus.finish_btn = 1'b1;
        cycles(high);
        bus.finish_btn = 1'b0;
        cycles(low);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, f0, j0, lat, seen;
        bus.coin_sense   = 4'b0100;
        bus.finish_btn   = 1'b0;
        bus.clear_credit = 1'b0;

        // Reset held 5 cycles with a coin present: all outputs stay 0.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("reset_outputs_zero",
                     {bus.coin, bus.drop_coin, bus.finish_coin, bus.reject, bus.jam, bus.credit}, 0);
        end
        sb_push(2'd2, 1'b0);
        reset = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.drop_coin && lat < 0) lat = k;
        end
        check_eq("first_drop_latency", lat, DEB + 1);
        check_eq("single_drop_while_held", drop_cnt, 1);
        bus.coin_sense = 4'b0000;
        cycles(6);

        // Two-cycle glitch must not be accepted.
        d0 = drop_cnt;
        bus.coin_sense = 4'b0010;
        cycles(2);
        bus.coin_sense = 4'b0000;
        cycles(10);
        check_eq("glitch_no_drop", drop_cnt - d0, 0);
        check_eq("glitch_credit", 32'(bus.credit), exp_credit);

        // Multi-line event rejected, then a clean coin.
        pulse_clear();
        check_eq("credit_cleared", 32'(bus.credit), 0);
        d0 = drop_cnt;
        r0 = reject_cnt;
        bus.coin_sense = 4'b0011;
        cycles(10);
        bus.coin_sense = 4'b0000;
        cycles(8);
        check_eq("reject_pulses", reject_cnt - r0, 1);
        check_eq("reject_no_drop", drop_cnt - d0, 0);
        check_eq("reject_credit", 32'(bus.credit), 0);
        insert_coin(2'd0, 6, 6);
        check_eq("credit_after_reject", 32'(bus.credit), 1);

        // Saturation with 52 ten-value coins.
        for (int k = 0; k < 52; k++) insert_coin(2'd3, 6, 6);
        check_eq("credit_saturated", 32'(bus.credit), CMAX);

        // clear_credit in the same cycle as EMIT.
        bus.coin_sense = 4'b0100;
        sb_push(2'd2, 1'b1);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.drop_coin) begin
                seen = 1;
                bus.clear_credit = 1'b1;
                cycles(1);
                bus.clear_credit = 1'b0;
            end
        end
        check_eq("clr_emit_seen", seen, 1);
        cycles(3);
        bus.coin_sense = 4'b0000;
        cycles(6);
        check_eq("credit_clear_on_emit", 32'(bus.credit), 5);

        // Stuck coin: one drop, jam for the tail of the hold.
        d0 = drop_cnt;
        j0 = jam_cnt;
        bus.coin_sense = 4'b1000;
        sb_push(2'd3, 1'b0);
        cycles(300);
        bus.coin_sense = 4'b0000;
        cycles(10);
        check_eq("stuck_one_drop", drop_cnt - d0, 1);
        check_eq("jam_cycles", jam_cnt - j0, 300 - DEB - MAXH + 1);
        check_eq("jam_released", 32'(bus.jam), 0);

        // Finish button: bounce then stable -> one pulse; short press ignored.
        pulse_clear();
        f0 = finish_cnt;
        bus.finish_btn = 1'b1; cycles(1);
        bus.finish_btn = 1'b0; cycles(1);
        bus.finish_btn = 1'b1; cycles(1);
        press(20, 12);
        check_eq("finish_bounce_one", finish_cnt - f0, 1);
        press(2, 10);
        check_eq("finish_short_press", finish_cnt - f0, 1);
        press(8, 10);
        check_eq("finish_second_press", finish_cnt - f0, 2);

`ifdef COIN_AUTO_FINISH_EN
        // Auto finish TMO cycles after the EMIT cycle, exactly once.
        pulse_clear();
        bus.coin_sense = 4'b0001;
        sb_push(2'd0, 1'b0);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.drop_coin) seen = 1;
        end
        check_eq("auto_drop_seen", seen, 1);
        f0 = finish_cnt;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 4) bus.coin_sense = 4'b0000;
            if (bus.finish_coin && lat < 0) lat = k;
        end
        check_eq("auto_finish_offset", lat, TMO);
        check_eq("auto_finish_once", finish_cnt - f0, 1);
`endif

        // Reset in the middle of a jam clears jam and credit.
        d0 = drop_cnt;
        bus.coin_sense = 4'b1000;
        sb_push(2'd3, 1'b0);
        cycles(DEB + 2 + MAXH + 4);
        check_eq("jam_before_reset", 32'(bus.jam), 1);
        reset = 1'b1;
        bus.coin_sense = 4'b0000;
        cycles(1);
        check_eq("jam_cleared_by_reset", 32'(bus.jam), 0);
        check_eq("credit_cleared_by_reset", 32'(bus.credit), 0);
        cycles(1);
        reset = 1'b0;
        exp_credit = 0;
        cycles(10);
        check_eq("reset_hold_one_drop", drop_cnt - d0, 1);
        check_eq("credit_after_reset", 32'(bus.credit), 0);

        // Reset during qualification produces no pulse.
        d0 = drop_cnt;
        bus.coin_sense = 4'b0010;
        cycles(3);
        reset = 1'b1;
        bus.coin_sense = 4'b0000;
        cycles(2);
        reset = 1'b0;
        cycles(12);
        check_eq("reset_qual_no_drop", drop_cnt - d0, 0);

        check_eq("sb_empty_at_end", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
